// File: rtl/exec_sequencer.sv
// exec_sequencer
// Multi-cycle control sequencer for the RV32 datapath. Each instruction is
// fetched over a valid/ready handshake, held stable for decode and execute,
// optionally given one data-memory transaction, and then retired in a single
// write-back cycle that commits the GPR write and the PC update together.
//
// Parameters:
//   RESET_PC  PC value after reset
//   TIMEOUT   max cycles in any one wait state before trapping (1..255)
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   if_req_valid/ready       fetch request handshake, if_addr = pc
//   if_rsp_valid/data        fetch response, latched into inst
//   inst, pc                 held instruction and current PC to the datapath
//   next_pc                  next-PC value from the datapath mux
//   reg_wr_i, mem_wr_i,
//   mem_to_reg_i, halt_i     decoded control from the CSG/IDU
//   dm_req_valid/we/ready    data-memory request handshake
//   dm_rsp_valid             data response / store acknowledgement
//   reg_wen                  one-cycle GPR write strobe in write-back
//   instret                  retired-instruction counter
//   halted, err              sticky ebreak / watchdog status
module exec_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        if_req_valid,
  input  logic        if_req_ready,
  output logic [31:0] if_addr,
  input  logic        if_rsp_valid,
  input  logic [31:0] if_rsp_data,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic [31:0] next_pc,
  input  logic        reg_wr_i,
  input  logic        mem_wr_i,
  input  logic        mem_to_reg_i,
  input  logic        halt_i,
  output logic        dm_req_valid,
  output logic        dm_req_we,
  input  logic        dm_req_ready,
  input  logic        dm_rsp_valid,
  output logic        reg_wen,
  output logic [31:0] instret,
  output logic        halted,
  output logic        err
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [7:0]  WD_LIMIT = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    FETCH,
    WAIT_IF,
    EXEC,
    MEM,
    WAIT_MEM,
    WB,
    HALT,
    ERROR
  } state_t;

  state_t     state;
  logic [7:0] wd_cnt;
  logic       wait_state;
  logic       wait_exit;
  logic       wd_expire;

  // Which states are guarded by the watchdog, and what lets each one leave.
  always_comb begin
    wait_state = 1'b0;
    wait_exit  = 1'b0;
    case (state)
      FETCH: begin
        wait_state = 1'b1;
        wait_exit  = if_req_ready;
      end
      WAIT_IF: begin
        wait_state = 1'b1;
        wait_exit  = if_rsp_valid;
      end
      MEM: begin
        wait_state = 1'b1;
        wait_exit  = dm_req_ready;
      end
      WAIT_MEM: begin
        wait_state = 1'b1;
        wait_exit  = dm_rsp_valid;
      end
      default: ;
    endcase
  end

  // An exit in the same cycle the limit is reached still wins over the trap.
  assign wd_expire = wait_state && !wait_exit && (wd_cnt == WD_LIMIT);

  // Sequencer: the watchdog count is cleared on every transition, so each
  // wait state gets its own full budget.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      inst    <= NOP_INST;
      instret <= '0;
      halted  <= 1'b0;
      err     <= 1'b0;
      wd_cnt  <= '0;
    end else if (wd_expire) begin
      state  <= ERROR;
      err    <= 1'b1;
      wd_cnt <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (if_req_ready) begin
            state  <= WAIT_IF;
            wd_cnt <= '0;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        WAIT_IF: begin
          // inst only ever changes here, which keeps decode stable to WB.
          if (if_rsp_valid) begin
            inst   <= if_rsp_data;
            state  <= EXEC;
            wd_cnt <= '0;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        EXEC: begin
          if (halt_i) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (mem_wr_i || mem_to_reg_i) begin
            state <= MEM;
          end else begin
            state <= WB;
          end
        end
        MEM: begin
          if (dm_req_ready) begin
            state  <= WAIT_MEM;
            wd_cnt <= '0;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        WAIT_MEM: begin
          if (dm_rsp_valid) begin
            state  <= WB;
            wd_cnt <= '0;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        WB: begin
          pc      <= next_pc;
          instret <= instret + 32'd1;
          state   <= FETCH;
        end
        default: ;
      endcase
    end
  end

  // Strobes are decoded from the state register rather than registered
  // separately: they must be low throughout reset yet the fetch request
  // has to be up in the very first cycle after release.
  assign if_req_valid = rst && (state == FETCH);
  assign dm_req_valid = rst && (state == MEM);
  assign reg_wen      = rst && (state == WB) && reg_wr_i;
  assign if_addr      = pc;
  assign dm_req_we    = mem_wr_i;

endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer
// Drives instruction transactions with chosen handshake delays and checks
// per-instruction handshake activity, retire timing and architectural state
// against a transaction-level model built from cycle counts per phase.
module tb_exec_sequencer;

  localparam int          TO     = 4;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  localparam int K_ALU   = 0;
  localparam int K_LOAD  = 1;
  localparam int K_STORE = 2;
  localparam int K_HALT  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req_valid;
  logic        if_req_ready = 1'b0;
  logic [31:0] if_addr;
  logic        if_rsp_valid = 1'b0;
  logic [31:0] if_rsp_data = '0;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] next_pc = '0;
  logic        reg_wr_i = 1'b0;
  logic        mem_wr_i = 1'b0;
  logic        mem_to_reg_i = 1'b0;
  logic        halt_i = 1'b0;
  logic        dm_req_valid;
  logic        dm_req_we;
  logic        dm_req_ready = 1'b0;
  logic        dm_rsp_valid = 1'b0;
  logic        reg_wen;
  logic [31:0] instret;
  logic        halted;
  logic        err;

  always #5 clk = ~clk;

  exec_sequencer #(.RESET_PC(RST_PC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .inst(inst), .pc(pc), .next_pc(next_pc),
    .reg_wr_i(reg_wr_i), .mem_wr_i(mem_wr_i), .mem_to_reg_i(mem_to_reg_i), .halt_i(halt_i),
    .dm_req_valid(dm_req_valid), .dm_req_we(dm_req_we), .dm_req_ready(dm_req_ready),
    .dm_rsp_valid(dm_rsp_valid), .reg_wen(reg_wen), .instret(instret),
    .halted(halted), .err(err)
  );

  typedef struct {
    int          a, b, c, d;
    int          kind;
    logic        reg_wr;
    logic [31:0] data;
    logic [31:0] npc;
  } txn_t;

  typedef struct {
    int   ifv, dmv, dmv_first, wen, wen_at;
    logic dm_we, err, halted;
  } res_t;

  typedef struct {
    txn_t t;
    res_t e;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  int          cyc;
  res_t        obs;
  logic [31:0] m_pc, m_instret, m_inst;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic nz();
    return ($urandom_range(0, 3) == 0);
  endfunction

  function automatic res_t clearRes();
    res_t r;
    r.ifv = 0; r.dmv = 0; r.dmv_first = 0; r.wen = 0; r.wen_at = 0;
    r.dm_we = 1'b0; r.err = 1'b0; r.halted = 1'b0;
    return r;
  endfunction

  // Phase-count model: each wait phase lasts delay+1 cycles, or traps after
  // TO+1 cycles when the awaited event comes too late.
  function automatic res_t predict(input txn_t t);
    res_t e;
    int   n;
    e = clearRes();
    if (t.a > TO) begin e.ifv = TO + 1; e.err = 1'b1; return e; end
    e.ifv = t.a + 1;
    n = t.a + 1;
    if (t.b > TO) begin e.err = 1'b1; return e; end
    n = n + t.b + 2;
    if (t.kind == K_HALT) begin e.halted = 1'b1; return e; end
    if (t.kind != K_ALU) begin
      e.dmv_first = n + 1;
      e.dm_we = (t.kind == K_STORE);
      if (t.c > TO) begin e.dmv = TO + 1; e.err = 1'b1; return e; end
      e.dmv = t.c + 1;
      n = n + t.c + 1;
      if (t.d > TO) begin e.err = 1'b1; return e; end
      n = n + t.d + 1;
    end
    n = n + 1;
    if (t.reg_wr) begin e.wen = 1; e.wen_at = n; end
    return e;
  endfunction

  // One clock of stimulus; outputs are tallied mid-cycle after the drive.
  task automatic oneCycle(input logic irr, input logic irv, input logic [31:0] ird,
                          input logic drr, input logic drv);
    @(negedge clk);
    if_req_ready = irr;
    if_rsp_valid = irv;
    if_rsp_data  = ird;
    dm_req_ready = drr;
    dm_rsp_valid = drv;
    #1;
    cyc++;
    if (if_req_valid) obs.ifv = obs.ifv + 1;
    if (dm_req_valid) begin
      obs.dmv = obs.dmv + 1;
      if (obs.dmv_first == 0) obs.dmv_first = cyc;
      if (dm_req_we) obs.dm_we = 1'b1;
    end
    if (reg_wen) begin
      obs.wen = obs.wen + 1;
      obs.wen_at = cyc;
    end
  endtask

  // ph: 0 FETCH, 1 WAIT_IF, 2 MEM, 3 WAIT_MEM. Stray responses are sprinkled
  // wherever they must be ignored, including the acceptance cycle.
  task automatic runPhase(input int ph, input int delay, input logic [31:0] data, output bit died);
    bit          go;
    logic [31:0] junk;
    died = 1'b0;
    for (int i = 0; i <= delay; i++) begin
      go   = (i == delay);
      junk = $urandom;
      case (ph)
        0:       oneCycle(go, nz(), junk, nz(), nz());
        1:       oneCycle(nz(), go, go ? data : junk, nz(), nz());
        2:       oneCycle(nz(), nz(), junk, go, nz());
        default: oneCycle(nz(), nz(), junk, nz(), go);
      endcase
      if (!go && i == TO) begin
        died = 1'b1;
        return;
      end
    end
  endtask

  task automatic applyStimulus(input txn_t t);
    bit died;
    obs = clearRes();
    cyc = 0;
    reg_wr_i     = t.reg_wr;
    mem_wr_i     = (t.kind == K_STORE);
    mem_to_reg_i = (t.kind == K_LOAD);
    halt_i       = (t.kind == K_HALT);
    next_pc      = t.npc;
    runPhase(0, t.a, t.data, died);
    if (!died) runPhase(1, t.b, t.data, died);
    if (!died) begin
      oneCycle(nz(), nz(), $urandom, nz(), nz());
      if (t.kind != K_HALT) begin
        if (t.kind != K_ALU) begin
          runPhase(2, t.c, t.data, died);
          if (!died) runPhase(3, t.d, t.data, died);
        end
        if (!died) oneCycle(nz(), nz(), $urandom, nz(), nz());
      end
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst pc", pc, RST_PC);
    checkOutput("rst inst", inst, NOP);
    checkOutput("rst instret", instret, 32'd0);
    checkOutput("rst halted", 32'(halted), 32'd0);
    checkOutput("rst err", 32'(err), 32'd0);
    checkOutput("rst if_req_valid", 32'(if_req_valid), 32'd0);
    checkOutput("rst dm_req_valid", 32'(dm_req_valid), 32'd0);
    checkOutput("rst reg_wen", 32'(reg_wen), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    m_pc = RST_PC;
    m_instret = '0;
    m_inst = NOP;
  endtask

  task automatic runTxn(input string tag, input txn_t t, input res_t e);
    checkOutput({tag, " if_addr"}, if_addr, m_pc);
    applyStimulus(t);
    @(posedge clk);
    #1;
    checkOutput({tag, " if_req cycles"}, 32'(obs.ifv), 32'(e.ifv));
    checkOutput({tag, " dm_req cycles"}, 32'(obs.dmv), 32'(e.dmv));
    checkOutput({tag, " dm_req first"}, 32'(obs.dmv_first), 32'(e.dmv_first));
    checkOutput({tag, " dm_req_we"}, 32'(obs.dm_we), 32'(e.dm_we));
    checkOutput({tag, " reg_wen pulses"}, 32'(obs.wen), 32'(e.wen));
    checkOutput({tag, " reg_wen cycle"}, 32'(obs.wen_at), 32'(e.wen_at));
    checkOutput({tag, " err"}, 32'(err), 32'(e.err));
    checkOutput({tag, " halted"}, 32'(halted), 32'(e.halted));
    if (t.a <= TO && t.b <= TO) m_inst = t.data;
    if (!e.err && !e.halted) begin
      m_pc = t.npc;
      m_instret = m_instret + 32'd1;
    end
    checkOutput({tag, " pc"}, pc, m_pc);
    checkOutput({tag, " instret"}, instret, m_instret);
    checkOutput({tag, " inst"}, inst, m_inst);
    if (e.err || e.halted) begin
      obs = clearRes();
      cyc = 0;
      repeat (4) oneCycle(1'b1, nz(), $urandom, 1'b1, nz());
      checkOutput({tag, " terminal requests"}, 32'(obs.ifv + obs.dmv + obs.wen), 32'd0);
      checkOutput({tag, " terminal pc"}, pc, m_pc);
      checkOutput({tag, " terminal instret"}, instret, m_instret);
      checkOutput({tag, " terminal status"}, {30'd0, halted, err}, {30'd0, e.halted, e.err});
      doReset();
    end
  endtask

  function automatic vec_t mkv(input int a, b, c, d, kind, input logic rw,
                               input logic [31:0] data, npc,
                               input int ifv, dmv, dmf, wen, wat,
                               input logic we, er, h);
    vec_t v;
    v.t.a = a; v.t.b = b; v.t.c = c; v.t.d = d; v.t.kind = kind;
    v.t.reg_wr = rw; v.t.data = data; v.t.npc = npc;
    v.e.ifv = ifv; v.e.dmv = dmv; v.e.dmv_first = dmf; v.e.wen = wen; v.e.wen_at = wat;
    v.e.dm_we = we; v.e.err = er; v.e.halted = h;
    return v;
  endfunction

  function automatic int rdelay();
    if ($urandom_range(0, 19) == 0) return $urandom_range(TO + 1, TO + 2);
    return $urandom_range(0, TO);
  endfunction

  vec_t vecs[12];
  txn_t rt;
  int   r;

  initial begin
    m_pc = RST_PC;
    m_instret = '0;
    m_inst = NOP;

    //            a  b  c  d  kind     rw    data          npc            ifv dmv dmf wen wat we  err h
    vecs[0]  = mkv(0, 0, 0, 0, K_ALU,   1'b1, 32'h00100093, 32'h80000004,  1,  0,  0,  1,  4, 0, 0, 0);
    vecs[1]  = mkv(0, 0, 3, 1, K_LOAD,  1'b1, 32'h0000a103, 32'h80000008,  1,  4,  4,  1, 10, 0, 0, 0);
    vecs[2]  = mkv(0, 0, 0, 0, K_STORE, 1'b0, 32'h0020a023, 32'h8000000c,  1,  1,  4,  0,  0, 1, 0, 0);
    vecs[3]  = mkv(4, 4, 0, 0, K_ALU,   1'b1, 32'h00208133, 32'h80000100,  5,  0,  0,  1, 12, 0, 0, 0);
    vecs[4]  = mkv(1, 2, 4, 4, K_LOAD,  1'b1, 32'h0040a183, 32'h80000104,  2,  5,  7,  1, 17, 0, 0, 0);
    vecs[5]  = mkv(10, 0, 0, 0, K_ALU,  1'b1, 32'h00300093, 32'h80000108,  5,  0,  0,  0,  0, 0, 1, 0);
    vecs[6]  = mkv(0, 5, 0, 0, K_ALU,   1'b1, 32'h00400093, 32'h80000004,  1,  0,  0,  0,  0, 0, 1, 0);
    vecs[7]  = mkv(0, 0, 5, 0, K_STORE, 1'b0, 32'h0020a223, 32'h80000004,  1,  5,  4,  0,  0, 1, 1, 0);
    vecs[8]  = mkv(0, 0, 0, 5, K_LOAD,  1'b1, 32'h0000a283, 32'h80000004,  1,  1,  4,  0,  0, 0, 1, 0);
    vecs[9]  = mkv(2, 0, 0, 0, K_ALU,   1'b0, 32'h00000463, 32'h80000040,  3,  0,  0,  0,  0, 0, 0, 0);
    vecs[10] = mkv(0, 1, 0, 0, K_HALT,  1'b0, 32'h00100073, 32'h80000044,  1,  0,  0,  0,  0, 0, 0, 1);
    vecs[11] = mkv(0, 0, 0, 0, K_ALU,   1'b1, 32'h00100093, 32'h80000004,  1,  0,  0,  1,  4, 0, 0, 0);

    repeat (2) @(posedge clk);
    doReset();

    for (int i = 0; i < 12; i++) runTxn($sformatf("vec%0d", i), vecs[i].t, vecs[i].e);

    // Load aborted by reset while its data request is still pending.
    obs = clearRes();
    cyc = 0;
    reg_wr_i = 1'b1; mem_to_reg_i = 1'b1; mem_wr_i = 1'b0; halt_i = 1'b0;
    oneCycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    oneCycle(1'b0, 1'b1, 32'h0000a303, 1'b0, 1'b0);
    oneCycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    oneCycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("abort dm_req seen", 32'(obs.dmv), 32'd1);
    checkOutput("abort inst latched", inst, 32'h0000a303);
    doReset();
    runTxn("after abort", vecs[0].t, vecs[0].e);

    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      rt.kind   = (r < 4) ? K_ALU : (r < 6) ? K_LOAD : (r < 9) ? K_STORE : K_HALT;
      rt.a      = rdelay();
      rt.b      = rdelay();
      rt.c      = rdelay();
      rt.d      = rdelay();
      rt.reg_wr = (rt.kind == K_STORE) ? nz() : 1'(($urandom_range(0, 4) != 0));
      rt.data   = $urandom;
      rt.npc    = $urandom & 32'hffff_fffc;
      runTxn($sformatf("rnd%0d", i), rt, predict(rt));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
